// File: rtl/router_fifo.sv
// Output-port buffer of the 1x3 router: header-tagged byte FIFO with a read-side packet countdown.
// Define ROUTER_FIFO_OCCUPANCY_EN to add the fill_level output.
module router_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  read_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
`ifdef ROUTER_FIFO_OCCUPANCY_EN
  ,
  output logic [ADDR_WIDTH:0]   fill_level
`endif
);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [6:0]          count;
  logic                wr_acc;
  logic                rd_acc;
  logic [DATA_WIDTH:0] rd_word;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
              (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    wr_acc  = write_enb && !full;
    rd_acc  = read_enb && !empty;
    rd_word = mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

`ifdef ROUTER_FIFO_OCCUPANCY_EN
  always_comb begin
    fill_level = wr_ptr - rd_ptr;
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        mem[wr_ptr[ADDR_WIDTH-1:0]] <= {lfd_state, data_in};
        wr_ptr                      <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        data_out <= rd_word[DATA_WIDTH-1:0];
        rd_ptr   <= rd_ptr + 1'b1;
        // Header carries payload length in bits 7:2; +1 accounts for the parity byte.
        if (rd_word[DATA_WIDTH]) begin
          count <= {1'b0, rd_word[7:2]} + 7'd1;
        end else if (count != 7'd0) begin
          count <= count - 7'd1;
        end
      end else if (count == 7'd0) begin
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Randomised and directed bench for router_fifo against a queue-based packet model.
module tb_router_fifo;

  localparam int DEPTH = 16;

  logic       clock      = 1'b0;
  logic       resetn     = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb  = 1'b0;
  logic       read_enb   = 1'b0;
  logic       lfd_state  = 1'b0;
  logic [7:0] data_in    = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
`ifdef ROUTER_FIFO_OCCUPANCY_EN
  logic [4:0] fill_level;
`endif

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    ,
    .fill_level (fill_level)
`endif
  );

  always #5 clock = ~clock;

  // Reference: a queue of {tag, byte} words plus the packet countdown.
  logic [8:0] q[$];
  int         m_cnt  = 0;
  logic [7:0] m_dout = 8'h00;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".data_out"}, {24'h0, data_out}, {24'h0, m_dout});
    check({tag, ".full"}, {31'h0, full}, {31'h0, q.size() == DEPTH});
    check({tag, ".empty"}, {31'h0, empty}, {31'h0, q.size() == 0});
`ifdef ROUTER_FIFO_OCCUPANCY_EN
    check({tag, ".fill_level"}, {27'h0, fill_level}, q.size());
`endif
  endtask

  task automatic step(input string tag, input logic we, input logic re, input logic lfd,
                      input logic [7:0] din, input logic srst);
    logic       m_full;
    logic       m_empty;
    logic [8:0] w;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    data_in    = din;
    soft_reset = srst;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    if (srst) begin
      q.delete();
      m_cnt  = 0;
      m_dout = 8'h00;
    end else begin
      if (re && !m_empty) begin
        w      = q.pop_front();
        m_dout = w[7:0];
        if (w[8]) m_cnt = int'(w[7:2]) + 1;
        else if (m_cnt > 0) m_cnt--;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (we && !m_full) q.push_back({lfd, din});
    end
    @(posedge clock);
    #1;
    check_outputs(tag);
  endtask

  task automatic wr(input string tag, input logic lfd, input logic [7:0] din);
    step(tag, 1'b1, 1'b0, lfd, din, 1'b0);
  endtask

  task automatic rd(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] pkt [5];
    #1;
    check_outputs("async_reset");
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset_hold");
    resetn = 1'b1;
    idle("reset_release");

    // Single packet: header 0C (length 3), payload, parity.
    pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h5A;
    for (int i = 0; i < 5; i++) wr("pkt_wr", i == 0, pkt[i]);
    for (int i = 0; i < 5; i++) begin
      rd("pkt_rd");
      check("pkt_byte", {24'h0, data_out}, {24'h0, pkt[i]});
    end
    idle("pkt_idle");
    check("pkt_end_zero", {24'h0, data_out}, 32'h0);

    // Fill, overflow attempt, drain.
    for (int i = 0; i < DEPTH; i++) wr("fill_wr", 1'b0, 8'(i + 8'h40));
    check("fill_full", {31'h0, full}, 32'h1);
    wr("overflow_wr", 1'b0, 8'hFF);
    for (int i = 0; i < DEPTH; i++) rd("fill_rd");
    idle("fill_idle");

    // Wrap-around.
    for (int i = 0; i < 10; i++) wr("wrap_wr1", 1'b0, 8'(i + 8'h80));
    for (int i = 0; i < 10; i++) rd("wrap_rd1");
    for (int i = 0; i < 12; i++) wr("wrap_wr2", 1'b0, 8'(i + 8'hA0));
    check("wrap_not_full", {31'h0, full}, 32'h0);
    for (int i = 0; i < 12; i++) rd("wrap_rd2");
    idle("wrap_idle");

    // Simultaneous read and write at full.
    for (int i = 0; i < DEPTH; i++) wr("simfull_wr", 1'b0, 8'(i + 8'h10));
    step("simfull_rw", 1'b1, 1'b1, 1'b0, 8'hAA, 1'b0);
    check("simfull_deassert", {31'h0, full}, 32'h0);
    wr("simfull_aa", 1'b0, 8'hAA);
    for (int i = 0; i < DEPTH; i++) rd("simfull_rd");
    idle("simfull_idle");

    // Simultaneous at empty: write wins, read ignored.
    step("simempty_rw", 1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
    rd("simempty_rd");
    idle("simempty_idle");

    // Soft reset mid-packet, then a fresh packet.
    wr("srst_wr", 1'b1, 8'h14);
    wr("srst_wr", 1'b0, 8'h01);
    wr("srst_wr", 1'b0, 8'h02);
    rd("srst_rd");
    step("srst", 1'b1, 1'b1, 1'b0, 8'h99, 1'b1);
    idle("srst_idle");
    check("srst_zero", {24'h0, data_out}, 32'h0);
    wr("post_wr", 1'b1, 8'h08);
    wr("post_wr", 1'b0, 8'hC1);
    wr("post_wr", 1'b0, 8'hC2);
    wr("post_wr", 1'b0, 8'h3C);
    for (int i = 0; i < 4; i++) rd("post_rd");
    idle("post_idle");

    // Random traffic with occasional soft reset.
    for (int i = 0; i < 3000; i++) begin
      step("rand", 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom_range(0, 99) == 0));
    end

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) wr("areset_wr", i == 0, 8'(8'h20 + i));
    rd("areset_rd");
    write_enb = 1'b0;
    read_enb  = 1'b0;
    resetn    = 1'b0;
    q.delete();
    m_cnt  = 0;
    m_dout = 8'h00;
    #1;
    check_outputs("areset");
    @(negedge clock);
    resetn = 1'b1;
    idle("areset_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- One output-port buffer of the 1x3 router. There are three instances, one per destination.
- Each instance takes one bit of the synchroniser's write_enb and soft_reset_N. It returns full_N and empty_N to the synchroniser.
- It stores header, payload and parity bytes, and tags the header byte of each packet.
- A byte countdown, loaded from each header, tracks packet boundaries on the read side.

Parameters:
- DATA_WIDTH, 8, byte width; the stored word is DATA_WIDTH+1 bits wide (extra bit = header tag).
- DEPTH, 16, number of entries; must be a power of two.
- ADDR_WIDTH, 4, log2(DEPTH). Pointers are ADDR_WIDTH+1 bits wide; the extra bit is the wrap bit.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- soft_reset  input  1  synchronous flush from the synchroniser's timeout counter.
- write_enb  input  1  write strobe for this port.
- read_enb  input  1  read strobe from the downstream consumer.
- lfd_state  input  1  high while the current write byte is a packet header.
- data_in  input  DATA_WIDTH  byte to be written.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  DEPTH entries are occupied.
- empty  output  1  zero entries are occupied.

Behaviour:
- Reset:
  - Asynchronous reset (resetn=0): pointers=0, packet count=0, data_out=0, all memory words=0, empty=1, full=0.
  - soft_reset=1 at a clock edge: same effect as resetn, applied synchronously. It takes priority over write_enb and read_enb in that cycle.
- Flags:
  - Both flags are combinational from the pointers.
  - empty = (wr_ptr == rd_ptr).
  - full = (address bits equal) AND (wrap bits differ).
- Write:
  - Accepted when write_enb=1 and full=0.
  - Stores {lfd_state, data_in} at wr_ptr[ADDR_WIDTH-1:0]; wr_ptr then increments modulo 2^(ADDR_WIDTH+1).
  - A write while full is dropped; memory and wr_ptr are unchanged.
- Read:
  - Accepted when read_enb=1 and empty=0.
  - data_out takes the stored byte at the next clock edge (1-cycle latency); rd_ptr then increments.
- Packet count (7 bits):
  - Reading a header-tagged word loads count = data[7:2] + 1, i.e. payload length plus parity.
  - Reading an untagged word with count>0 decrements count.
  - Reading an untagged word with count=0 (malformed stream) still outputs the byte; count stays 0.
- data_out when idle:
  - If no read is accepted and count=0, data_out <= 0.
  - If no read is accepted and count>0, data_out holds its value.
- Simultaneous events:
  - Read and write in the same cycle, neither boundary hit: both complete and occupancy is unchanged.
  - At full with read and write both asserted: the read completes and the write is dropped (full is sampled before the edge).
  - At empty with read and write both asserted: the write completes and the read is ignored; data_out follows the idle rule.
- Reset mid-packet: any partially written or unread packet is discarded. No partial byte appears on data_out after the reset.

Optional Feature:
- Macro: ROUTER_FIFO_OCCUPANCY_EN.
- Defined:
  - Adds output port fill_level [ADDR_WIDTH:0], equal to wr_ptr - rd_ptr (modulo arithmetic), range 0..DEPTH.
  - fill_level resets to 0 on resetn or soft_reset.
  - It updates combinationally with the pointers.
- Undefined: the port does not exist and no occupancy subtractor is built. All other behaviour is identical.

Test Plan:
- Reset then idle: resetn low for 2 cycles, then high -> empty=1, full=0, data_out=8'h00 (fill_level=0 if enabled).
- Single packet: write header 8'h0C with lfd_state=1 (length 3), then payload 11,22,33 and parity 5A. Read 5 times -> data_out sequence 0C,11,22,33,5A, each one cycle after its read_enb. count reaches 0 and data_out=00 on the next idle cycle; empty=1.
- Fill and overflow: 16 writes -> full=1 after the 16th. A 17th write with value FF -> dropped. 16 reads return the original bytes in order, with no FF.
- Wrap-around: write 10, read 10, write 12 -> full=0, empty=0, fill_level=12. Reads return the 12 bytes in order across the address wrap.
- Simultaneous at full: buffer full, read_enb=1 and write_enb=1 with data AA -> one byte out, full deasserts, AA not stored. The next write of AA succeeds.
- Soft reset mid-packet: header 8'h14 plus 2 payload bytes written, 1 byte read, then soft_reset=1 for 1 cycle -> empty=1, count=0, data_out=00. A new packet written afterwards reads back correctly.
